dcache_responder: RTL

DCACHE_RESPONDER -- requirements
Module: dcache_responder

---
 rtl/dcache_responder_if.sv | 26 ++
 rtl/dcache_responder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dcache_responder_if.sv
// Bundles the pipeline-side dcache request/response signals with the
// backing-memory request/ack signals that the responder sits between.
interface dcache_responder_if;
    logic [31:0] dcache_addr;
    logic [31:0] dcache_wdata;
    logic        dcache_en;
    logic        dcache_wr;
    logic [31:0] dcache_rdata;
    logic        dcache_rdy;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  dcache_addr, dcache_wdata, dcache_en, dcache_wr, mem_rdata, mem_ack,
        output dcache_rdata, dcache_rdy, mem_addr, mem_wdata, mem_req, mem_we
    );

    modport master (
        output dcache_addr, dcache_wdata, dcache_en, dcache_wr, mem_rdata, mem_ack,
        input  dcache_rdata, dcache_rdy, mem_addr, mem_wdata, mem_req, mem_we
    );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, one-word-per-line, write-through/no-write-allocate data cache
// with zero-latency read hits and a single outstanding backing-memory request.
//
// state | meaning
// IDLE  | accept request; read hits answered combinationally
// MEM   | backing-memory request outstanding, waiting for mem_ack
// DONE  | one-cycle completion; return register presented to pipeline
module dcache_responder #(
    parameter int INDEX_BITS = 4
) (
    input  logic              clock,
    input  logic              reset,
    dcache_responder_if.slave bus
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

    state_t state, state_nxt;

    logic [LINES-1:0]      valid;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];
    logic [31:0]           ret_data;

    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [31:0]           mem_addr_q;
    logic [31:0]           mem_wdata_q;

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_BITS-1:0] mem_idx;
    logic [TAG_W-1:0]      mem_tag;
    logic                  hit;
    logic                  wr_hit;
    logic                  start_mem;
    logic                  mem_done;
    logic                  rdy_c;
    logic [31:0]           rdata_c;
    logic                  unused_addr_lsb;

    assign req_idx = bus.dcache_addr[INDEX_BITS+1:2];
    assign req_tag = bus.dcache_addr[31:INDEX_BITS+2];
    assign unused_addr_lsb = ^bus.dcache_addr[1:0];

    // The outstanding request address doubles as the line locator at ack time.
    assign mem_idx = mem_addr_q[INDEX_BITS+1:2];
    assign mem_tag = mem_addr_q[31:INDEX_BITS+2];

    assign hit    = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign wr_hit = valid[mem_idx] && (tag_mem[mem_idx] == mem_tag);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rdy_c     = 1'b0;
        rdata_c   = 32'd0;
        start_mem = 1'b0;
        mem_done  = 1'b0;
        case (state)
            IDLE: begin
                rdy_c = !bus.dcache_en || (hit && !bus.dcache_wr);
                if (bus.dcache_en && hit && !bus.dcache_wr) begin
                    rdata_c = data_mem[req_idx];
                end
                if (bus.dcache_en && !(hit && !bus.dcache_wr)) begin
                    start_mem = 1'b1;
                    state_nxt = MEM;
                end
            end
            MEM: begin
                if (bus.mem_ack) begin
                    mem_done  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                rdy_c     = 1'b1;
                rdata_c   = ret_data;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            ret_data    <= 32'd0;
            valid       <= '0;
        end else begin
            if (start_mem) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= bus.dcache_wr;
                mem_addr_q  <= {bus.dcache_addr[31:2], 2'b00};
                mem_wdata_q <= bus.dcache_wdata;
            end else if (mem_done) begin
                mem_req_q <= 1'b0;
                mem_we_q  <= 1'b0;
            end
            if (mem_done && !mem_we_q) begin
                ret_data       <= bus.mem_rdata;
                valid[mem_idx] <= 1'b1;
            end
        end
    end

    // Line storage needs no reset: valid bits gate every use of it.
    always_ff @(posedge clock) begin
        if (mem_done) begin
            if (!mem_we_q) begin
                data_mem[mem_idx] <= bus.mem_rdata;
                tag_mem[mem_idx]  <= mem_tag;
            end else if (wr_hit) begin
                data_mem[mem_idx] <= mem_wdata_q;
            end
        end
    end

    assign bus.dcache_rdy   = rdy_c;
    assign bus.dcache_rdata = rdata_c;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
endmodule
